// File: rtl/pipe_reg_n.sv
// Elastic pipeline register chain: DEPTH valid/ready stages that collapse bubbles.
// The ready chain is combinational, so in_ready follows out_ready in the same cycle.
module pipe_reg_n #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CntW-1:0]  count
);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [CntW-1:0]  r_count;

  logic [DEPTH:0]   w_ready;
  logic [DEPTH-1:0] w_in_valid;
  logic [WIDTH-1:0] w_in_data [DEPTH];
  logic [DEPTH-1:0] w_valid_d;
  logic [CntW-1:0]  w_count_d;

  // Stage i is ready when out_ready is high or any stage from i downstream is empty.
  always_comb begin
    logic v_acc;
    v_acc = out_ready;
    w_ready[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      v_acc      = v_acc || !r_valid[i];
      w_ready[i] = v_acc;
    end
  end

  assign in_ready = w_ready[0] && !flush;

  always_comb begin
    w_in_valid[0] = in_valid && in_ready;
    w_in_data[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      w_in_valid[i] = r_valid[i-1];
      w_in_data[i]  = r_data[i-1];
    end
  end

  always_comb begin
    w_valid_d = r_valid;
    w_count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush) begin
        w_valid_d[i] = 1'b0;
      end else if (w_ready[i]) begin
        w_valid_d[i] = w_in_valid[i];
      end
      w_count_d = w_count_d + CntW'(w_valid_d[i]);
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_valid <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_valid <= w_valid_d;
      r_count <= w_count_d;
      // Data only moves with a valid item; empty stages keep their old contents.
      for (int i = 0; i < DEPTH; i++) begin
        if (!flush && w_ready[i] && w_in_valid[i]) begin
          r_data[i] <= w_in_data[i];
        end
      end
    end
  end

  assign out_valid = r_valid[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];
  assign count     = r_count;

endmodule

// File: tb/tb_pipe_reg_n.sv
// Bench for pipe_reg_n: directed scenarios then random traffic, checked against a
// queue-of-item-positions model of the pipeline.
module tb_pipe_reg_n;

  localparam int WIDTH = 64;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             clear = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [2:0]       count;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: each held item carries its stage index, oldest first.
  int               q_pos[$];
  logic [WIDTH-1:0] q_dat[$];

  pipe_reg_n #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .clear     (clear),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q_pos.delete();
    q_dat.delete();
  endtask

  // One cycle: drive, check against the model just before the edge, advance the model.
  task automatic step(input logic iv, input logic [63:0] id, input logic ordy, input logic fl);
    int   np[$];
    int   lim;
    int   nxt;
    int   s;
    logic e_ov;
    logic e_ir;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    #2;
    e_ov = (q_pos.size() > 0) && (q_pos[0] == DEPTH - 1);
    s    = (e_ov && ordy) ? 1 : 0;
    lim  = DEPTH;
    for (int j = s; j < q_pos.size(); j++) begin
      nxt = (q_pos[j] + 1 < lim - 1) ? q_pos[j] + 1 : lim - 1;
      np.push_back(nxt);
      lim = nxt;
    end
    e_ir = (lim >= 1) && !fl;
    chk("out_valid", {63'd0, out_valid}, {63'd0, e_ov});
    if (e_ov) chk("out_data", out_data, q_dat[0]);
    chk("in_ready", {63'd0, in_ready}, {63'd0, e_ir});
    chk("count", {61'd0, count}, 64'(q_pos.size()));
    if (fl) begin
      model_clear();
    end else begin
      if (s == 1) void'(q_dat.pop_front());
      q_pos = np;
      if (iv && e_ir) begin
        q_pos.push_back(0);
        q_dat.push_back(id);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held across edges, with in_valid offered and flush toggled.
    in_valid = 1'b1;
    in_data  = 64'h55;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_count", {61'd0, count}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    flush = 1'b1;
    #1;
    chk("rst_in_ready_flush", {63'd0, in_ready}, 64'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    #4;
    clear = 1'b0;
    @(posedge clk);
    #1;

    // Streaming with out_ready high.
    for (int k = 1; k <= 8; k++) step(1'b1, 64'(k), 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) step(1'b0, 64'd0, 1'b1, 1'b0);

    // Backpressure: 0x5 held until out_ready rises.
    for (int k = 1; k <= 5; k++) step(1'b1, 64'(k), 1'b0, 1'b0);
    chk("bp_count", {61'd0, count}, 64'd4);
    step(1'b1, 64'd5, 1'b0, 1'b0);
    step(1'b1, 64'd5, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) step(1'b0, 64'd0, 1'b1, 1'b0);

    // Bubble collapse.
    step(1'b1, 64'hA, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 64'd0, 1'b0, 1'b0);
    step(1'b1, 64'hB, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 64'd0, 1'b0, 1'b0);
    chk("collapse_count", {61'd0, count}, 64'd2);
    for (int k = 0; k < 4; k++) step(1'b0, 64'd0, 1'b1, 1'b0);

    // Flush a full pipeline while 0xF is offered and an output handshake occurs.
    for (int k = 1; k <= 4; k++) step(1'b1, 64'(16 + k), 1'b0, 1'b0);
    step(1'b1, 64'hF, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, 64'd0, 1'b1, 1'b0);

    // Clear asserted between edges with three items held.
    for (int k = 1; k <= 3; k++) step(1'b1, 64'(32 + k), 1'b0, 1'b0);
    #2;
    clear = 1'b1;
    in_valid = 1'b1;
    in_data = 64'h77;
    #1;
    chk("clr_out_valid", {63'd0, out_valid}, 64'd0);
    chk("clr_out_data", out_data, 64'd0);
    chk("clr_count", {61'd0, count}, 64'd0);
    @(posedge clk);
    #1;
    chk("clr_edge_count", {61'd0, count}, 64'd0);
    clear = 1'b0;
    model_clear();
    for (int k = 0; k < 6; k++) step(1'b0, 64'd0, 1'b1, 1'b0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 9) < 7), {$urandom, $urandom}, ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 19) == 0));
    end
    for (int k = 0; k < 6; k++) step(1'b0, 64'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
